// File: rtl/demux_1to16_seq.sv
// 1-to-16 sequential demultiplexer: manual bit writes in IDLE, or a 16-cycle serial scan into out.
// Define DEMUX_SCAN_MSB_FIRST_EN to scan 15->0 instead of the default 0->15.
module demux_1to16_seq #(
  parameter logic [15:0] OUT_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  input  logic [3:0]  sel,
  input  logic        we,
  input  logic        scan_start,
  output logic [15:0] out,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_o
);

`ifdef DEMUX_SCAN_MSB_FIRST_EN
  localparam logic [3:0] FIRST_IDX = 4'd15;
  localparam logic [3:0] LAST_IDX  = 4'd0;
  localparam logic [3:0] IDX_STEP  = 4'hF;
`else
  localparam logic [3:0] FIRST_IDX = 4'd0;
  localparam logic [3:0] LAST_IDX  = 4'd15;
  localparam logic [3:0] IDX_STEP  = 4'h1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] out_q;
  logic [3:0]  idx_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= OUT_RST;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // scan_start takes priority; a simultaneous manual write is dropped
          if (scan_start) begin
            state_q <= SCAN;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b1;
          end else if (we) begin
            out_q[sel] <= in;
          end
        end
        SCAN: begin
          out_q[idx_q] <= in;
          if (idx_q == LAST_IDX) begin
            // idx holds at the last index; the return to 0 happens on leaving DONE
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_STEP;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          idx_q   <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign idx     = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_demux_1to16_seq.sv
// Randomized and directed bench for demux_1to16_seq against a position-counting reference model.
module tb_demux_1to16_seq;

  localparam logic [15:0] OUT_RST = 16'h0000;
`ifdef DEMUX_SCAN_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_s = 1'b0;
  logic [3:0]  sel_s = 4'd0;
  logic        we_s = 1'b0;
  logic        ss_s = 1'b0;
  logic [15:0] out_s;
  logic [3:0]  idx_s;
  logic        busy_s;
  logic        done_s;
  logic [1:0]  state_s;

  int checks = 0;
  int errors = 0;

  // Reference: pos = -1 idle, 0..15 = scan bits already captured, 16 = done cycle.
  logic [15:0] exp_out;
  int          pos;
  logic [15:0] exp_q[$];

  demux_1to16_seq #(.OUT_RST(OUT_RST)) dut (
    .clk(clk), .rst(rst), .in(in_s), .sel(sel_s), .we(we_s), .scan_start(ss_s),
    .out(out_s), .idx(idx_s), .busy(busy_s), .done(done_s), .state_o(state_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bit_of(input int p);
    return MSB_FIRST ? 15 - p : p;
  endfunction

  task automatic model_reset();
    exp_out = OUT_RST;
    pos     = -1;
  endtask

  task automatic model_edge(input logic i, input logic [3:0] s, input logic w, input logic st);
    if (pos == -1) begin
      if (st) pos = 0;
      else if (w) exp_out[s] = i;
    end else if (pos < 16) begin
      exp_out[bit_of(pos)] = i;
      pos++;
    end else begin
      pos = -1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] e_idx;
    if (pos == -1)      e_idx = 4'd0;
    else if (pos == 16) e_idx = 4'(bit_of(15));
    else                e_idx = 4'(bit_of(pos));
    check({tag, ".out"},  out_s, exp_out);
    check({tag, ".idx"},  {12'd0, idx_s}, {12'd0, e_idx});
    check({tag, ".busy"}, {15'd0, busy_s}, {15'd0, (pos >= 0 && pos < 16)});
    check({tag, ".done"}, {15'd0, done_s}, {15'd0, (pos == 16)});
    if (pos == 16 && exp_q.size() > 0) check({tag, ".word"}, out_s, exp_q.pop_front());
  endtask

  task automatic step(input string tag, input logic i, input logic [3:0] s, input logic w, input logic st);
    @(negedge clk);
    in_s = i; sel_s = s; we_s = w; ss_s = st;
    @(posedge clk);
    model_edge(i, s, w, st);
    #1;
    check_outputs(tag);
  endtask

  // noisy: hold we=1, sel=0, scan_start=1 through the scan, all of which must be ignored
  task automatic run_scan(input logic [15:0] word, input bit noisy);
    exp_q.push_back(word);
    step("scan_go", 1'b0, 4'd5, 1'b0, 1'b1);
    for (int p = 0; p < 16; p++)
      step("scan_bit", word[bit_of(p)], noisy ? 4'd0 : 4'(p), noisy, noisy);
    step("scan_done", 1'b0, 4'd0, noisy, noisy);
    step("scan_idle", 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    check("rst.out", out_s, OUT_RST);
    check("rst.flags", {10'd0, idx_s, busy_s, done_s}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    step("wr3", 1'b1, 4'h3, 1'b1, 1'b0);
    check("wr3.abs", out_s, 16'h0008);
    step("wrc", 1'b1, 4'hc, 1'b1, 1'b0);
    check("wrc.abs", out_s, 16'h1008);

    run_scan(16'h30ab, 1'b0);
    check("scan.abs", out_s, 16'h30ab);
    run_scan(16'hc35a, 1'b1);
    check("noisy.abs", out_s, 16'hc35a);

    // we and scan_start together: write dropped, scan starts
    step("collide", ~out_s[7], 4'd7, 1'b1, 1'b1);
    for (int p = 0; p < 16; p++) step("collide_bit", 1'($urandom_range(0, 1)), 4'd0, 1'b0, 1'b0);
    step("collide_done", 1'b0, 4'd0, 1'b0, 1'b0);

    // reset mid-scan after 8 captured bits
    step("abort_go", 1'b0, 4'd0, 1'b0, 1'b1);
    for (int p = 0; p < 8; p++) step("abort_bit", 1'b1, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("abort.out", out_s, OUT_RST);
    check("abort.flags", {10'd0, idx_s, busy_s, done_s}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) step("abort_idle", 1'b1, 4'd2, 1'b0, 1'b0);
    step("post_rst_wr", 1'b1, 4'd9, 1'b1, 1'b0);

    for (int c = 0; c < 600; c++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
